// File: rtl/captura_jogada.sv
// Player button capture: two-flop synchronizer, press/release debounce and
// one-hot validation, emitting a single valid/invalid pulse per press cycle.
module captura_jogada #(
    parameter int unsigned DEBOUNCE_CYCLES = 50,
    parameter int unsigned N               = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic       limpa,
    input  logic [3:0] botoes,
    output logic [3:0] jogada,
    output logic       jogada_valida,
    output logic       jogada_invalida,
    output logic       ocupado,
    output logic [2:0] db_estado
);
    localparam int unsigned W  = 4;
    localparam int unsigned SW = 3;
    localparam logic [N-1:0] CNT_LAST = N'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [SW-1:0] {
        OCIOSO    = 3'd0,
        FILTRANDO = 3'd1,
        CAPTURADO = 3'd2,
        INVALIDO  = 3'd3,
        SEGURANDO = 3'd4,
        SOLTANDO  = 3'd5
    } estado_t;

    estado_t       state_q, state_d;
    logic [W-1:0]  sync1_q, sinc_q;
    logic [W-1:0]  cand_q, cand_d;
    logic [W-1:0]  jogada_q, jogada_d;
    logic [N-1:0]  cnt_q, cnt_d;
    logic          valida_q, invalida_q, ocupado_q;
    logic [SW-1:0] estado_q;

    function automatic logic one_hot(input logic [W-1:0] v);
        return (v != '0) && ((v & (v - W'(1))) == '0);
    endfunction

    // Next-state, candidate and shared debounce counter
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        case (state_q)
            OCIOSO: begin
                if (sinc_q != '0) begin
                    if (habilita) begin
                        cand_d  = sinc_q;
                        cnt_d   = '0;
                        state_d = FILTRANDO;
                    end else begin
                        state_d = SEGURANDO;
                    end
                end
            end
            FILTRANDO: begin
                if (!habilita) begin
                    state_d = SEGURANDO;
                end else if (sinc_q == '0) begin
                    state_d = OCIOSO;
                end else if (sinc_q != cand_q) begin
                    cand_d = sinc_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = one_hot(cand_q) ? CAPTURADO : INVALIDO;
                end else begin
                    cnt_d = cnt_q + N'(1);
                end
            end
            CAPTURADO, INVALIDO: begin
                state_d = SEGURANDO;
            end
            SEGURANDO: begin
                if (sinc_q == '0) begin
                    cnt_d   = '0;
                    state_d = SOLTANDO;
                end
            end
            SOLTANDO: begin
                if (sinc_q != '0) begin
                    state_d = SEGURANDO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = OCIOSO;
                end else begin
                    cnt_d = cnt_q + N'(1);
                end
            end
            default: begin
                state_d = OCIOSO;
            end
        endcase

        // A capture on the same edge as a clear takes priority
        jogada_d = limpa ? '0 : jogada_q;
        if (state_d == CAPTURADO) begin
            jogada_d = cand_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sinc_q     <= '0;
            state_q    <= OCIOSO;
            cand_q     <= '0;
            cnt_q      <= '0;
            jogada_q   <= '0;
            valida_q   <= 1'b0;
            invalida_q <= 1'b0;
            ocupado_q  <= 1'b0;
            estado_q   <= '0;
        end else begin
            sync1_q    <= botoes;
            sinc_q     <= sync1_q;
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            jogada_q   <= jogada_d;
            valida_q   <= (state_d == CAPTURADO);
            invalida_q <= (state_d == INVALIDO);
            ocupado_q  <= (state_d != OCIOSO);
            estado_q   <= state_d;
        end
    end

    assign jogada          = jogada_q;
    assign jogada_valida   = valida_q;
    assign jogada_invalida = invalida_q;
    assign ocupado         = ocupado_q;
    assign db_estado       = estado_q;

endmodule

// File: tb/tb_captura_jogada.sv
// Bench for captura_jogada: run-length reference model checked every cycle,
// directed scenarios with literal expectations, then randomized button traffic.
module tb_captura_jogada;
    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       habilita = 1'b0;
    logic       limpa = 1'b0;
    logic [3:0] botoes = 4'b0000;
    logic [3:0] jogada;
    logic       jogada_valida;
    logic       jogada_invalida;
    logic       ocupado;
    logic [2:0] db_estado;

    int n_vec = 0;
    int n_mis = 0;
    int val_seen = 0;
    int inv_seen = 0;

    captura_jogada #(.DEBOUNCE_CYCLES(D), .N(3)) dut (
        .clock(clock),
        .reset(reset),
        .habilita(habilita),
        .limpa(limpa),
        .botoes(botoes),
        .jogada(jogada),
        .jogada_valida(jogada_valida),
        .jogada_invalida(jogada_invalida),
        .ocupado(ocupado),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: phases 0 idle,1 filter,2 captured,3 invalid,4 held,5 releasing.
    // Acceptance = the synchronized value has been identical for D+1 samples.
    logic [3:0] m_s1, m_s2, m_prev, m_jog, m_sinc;
    int m_run, m_rel, m_ph, m_nx;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_prev = 0; m_jog = 0;
            m_run = 1; m_rel = 0; m_ph = 0;
        end else begin
            m_sinc = m_s2;
            if (m_sinc == m_prev) m_run++; else m_run = 1;
            m_prev = m_sinc;
            m_nx = m_ph;
            case (m_ph)
                0: if (m_sinc != 0) m_nx = habilita ? 1 : 4;
                1: begin
                    if (!habilita) m_nx = 4;
                    else if (m_sinc == 0) m_nx = 0;
                    else if (m_run == D + 1) m_nx = ($countones(m_sinc) == 1) ? 2 : 3;
                end
                2, 3: m_nx = 4;
                4: if (m_sinc == 0) begin m_nx = 5; m_rel = 1; end
                5: begin
                    if (m_sinc != 0) m_nx = 4;
                    else begin
                        m_rel++;
                        if (m_rel == D + 1) m_nx = 0;
                    end
                end
                default: m_nx = 0;
            endcase
            if (limpa) m_jog = 0;
            if (m_nx == 2) m_jog = m_sinc;
            m_ph = m_nx;
            m_s2 = m_s1;
            m_s1 = botoes;
        end
    end

    always @(negedge clock) begin
        chk("jogada", int'(jogada), int'(m_jog));
        chk("jogada_valida", int'(jogada_valida), int'(m_ph == 2));
        chk("jogada_invalida", int'(jogada_invalida), int'(m_ph == 3));
        chk("ocupado", int'(ocupado), int'(m_ph != 0));
        chk("db_estado", int'(db_estado), m_ph);
        if (jogada_valida) val_seen++;
        if (jogada_invalida) inv_seen++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic hold(input logic [3:0] b, input int n);
        botoes = b;
        cyc(n);
    endtask

    task automatic release_all();
        botoes = 4'b0000;
        cyc(12);
        chk("idle_after_release", int'(ocupado), 0);
    endtask

    int v0, i0;

    initial begin
        cyc(2);
        reset = 1'b0;
        habilita = 1'b1;
        chk("reset_jogada", int'(jogada), 0);
        chk("reset_estado", int'(db_estado), 0);
        cyc(3);

        // Clean press: pulse in the cycle after edge D+3
        v0 = val_seen;
        botoes = 4'b0100;
        cyc(6);
        chk("latency_early", int'(jogada_valida), 0);
        cyc(1);
        chk("latency_pulse", int'(jogada_valida), 1);
        chk("latency_jogada", int'(jogada), 4);
        cyc(13);
        botoes = 4'b0000;
        cyc(6);
        chk("release_busy", int'(ocupado), 1);
        cyc(1);
        chk("release_idle", int'(ocupado), 0);
        chk("clean_count", val_seen - v0, 1);

        // Bounce
        v0 = val_seen;
        for (int i = 0; i < 5; i++) begin
            hold(4'b0100, 1);
            hold(4'b0100, 1);
            hold(4'b0000, 2);
        end
        chk("bounce_none", val_seen - v0, 0);
        hold(4'b0100, 12);
        chk("bounce_one", val_seen - v0, 1);
        chk("bounce_jogada", int'(jogada), 4);
        release_all();

        // Multi-press keeps prior play
        hold(4'b0010, 10);
        release_all();
        v0 = val_seen; i0 = inv_seen;
        hold(4'b0011, 12);
        chk("multi_inv", inv_seen - i0, 1);
        chk("multi_val", val_seen - v0, 0);
        chk("multi_jogada", int'(jogada), 2);
        release_all();

        // Hold and roll
        v0 = val_seen;
        hold(4'b0001, 10);
        hold(4'b1001, 6);
        hold(4'b1000, 6);
        chk("roll_count", val_seen - v0, 1);
        chk("roll_jogada", int'(jogada), 1);
        release_all();
        hold(4'b1000, 10);
        chk("roll_next", val_seen - v0, 2);
        chk("roll_next_jogada", int'(jogada), 8);
        release_all();

        // Press begun while disabled
        v0 = val_seen;
        habilita = 1'b0;
        hold(4'b0010, 4);
        habilita = 1'b1;
        hold(4'b0010, 10);
        chk("dis_none", val_seen - v0, 0);
        chk("dis_jogada", int'(jogada), 8);
        release_all();
        hold(4'b0010, 10);
        chk("dis_fresh", val_seen - v0, 1);
        chk("dis_fresh_jogada", int'(jogada), 2);
        release_all();

        // Async reset mid-filtering
        v0 = val_seen;
        botoes = 4'b0100;
        cyc(4);
        #2 reset = 1'b1;
        #1;
        chk("arst_jogada", int'(jogada), 0);
        chk("arst_valida", int'(jogada_valida), 0);
        chk("arst_invalida", int'(jogada_invalida), 0);
        chk("arst_ocupado", int'(ocupado), 0);
        chk("arst_estado", int'(db_estado), 0);
        botoes = 4'b0000;
        cyc(2);
        reset = 1'b0;
        cyc(12);
        chk("arst_no_pulse", val_seen - v0, 0);

        // Clear
        hold(4'b0100, 10);
        release_all();
        chk("clear_before", int'(jogada), 4);
        limpa = 1'b1;
        cyc(1);
        limpa = 1'b0;
        chk("clear_after", int'(jogada), 0);

        // Randomized traffic
        for (int k = 0; k < 80; k++) begin
            int r, n;
            r = $urandom_range(0, 9);
            if (r <= 5) botoes = 4'(1 << $urandom_range(0, 3));
            else if (r <= 7) botoes = 4'b0000;
            else botoes = 4'($urandom_range(1, 15));
            habilita = ($urandom_range(0, 7) != 0);
            n = $urandom_range(1, 10);
            for (int c = 0; c < n; c++) begin
                limpa = ($urandom_range(0, 15) == 0);
                cyc(1);
            end
        end
        limpa = 1'b0;
        habilita = 1'b1;
        release_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
